// File: rtl/score_7seg_pkg.sv
// rtl/score_7seg_pkg.sv - shared types and segment constants for the score display
package score_7seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam int BCD_DIGITS = 10;
    localparam int BIN_WIDTH  = 32;

    // active-low, bit0 = a .. bit6 = g
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/m_score_7seg_bin2bcd.sv
// rtl/m_score_7seg_bin2bcd.sv - sequential 32-bit double-dabble, one bit per cycle
module m_bin2bcd_seq
    import score_7seg_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BIN_WIDTH-1:0]      bin,
    output logic                      busy,
    output logic                      done,
    output logic [BCD_DIGITS*4-1:0]   bcd
);

    logic [BIN_WIDTH-1:0]    bin_q;
    logic [BCD_DIGITS*4-1:0] bcd_q;
    logic [BCD_DIGITS*4-1:0] adj;
    logic [4:0]              cnt;
    logic                    busy_q;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
        end else if (start && !busy_q) begin
            bin_q  <= bin;
            bcd_q  <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            {bcd_q, bin_q} <= {adj[BCD_DIGITS*4-2:0], bin_q, 1'b0};
            cnt            <= cnt + 5'd1;
            if (cnt == 5'(BIN_WIDTH - 1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    // High during the cycle of the final shift; bcd holds the result on the next cycle.
    assign done = busy_q && (cnt == 5'(BIN_WIDTH - 1));
    assign busy = busy_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/m_score_7seg.sv
// rtl/m_score_7seg.sv - signed score to BCD, formatting and multiplexed 7-segment scan
module m_score_7seg
    import score_7seg_pkg::*;
#(
    parameter int SCAN_DIV   = 40000,
    parameter int NUM_DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  w_rst_n,
    input  logic [31:0]           i_score,
    input  logic                  i_valid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [6:0]            o_sg,
    output logic [NUM_DIGITS-1:0] o_an
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);

    state_t state, state_next;

    logic                         sign_q;
    logic                         accept;
    logic [BIN_WIDTH-1:0]         mag;
    logic                         conv_busy;
    logic                         conv_done;
    logic [BCD_DIGITS*4-1:0]      bcd;
    logic [NUM_DIGITS-1:0][6:0]   disp_q;
    logic [NUM_DIGITS-1:0][6:0]   disp_next;
    logic [IW-1:0]                msd;
    logic                         ovf;
    logic [PW-1:0]                presc;
    logic [IW-1:0]                idx;

    assign accept = i_valid && (state == ST_IDLE) && !conv_busy;
    assign mag    = i_score[31] ? (~i_score + 32'd1) : i_score;
    assign o_busy = (state != ST_IDLE);

    m_bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (w_rst_n),
        .start (accept),
        .bin   (mag),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (bcd)
    );

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept)    state_next = ST_CONV;
            ST_CONV:   if (conv_done) state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Formatting: overflow dashes, leading-zero blanking, minus sign left of the top digit.
    always_comb begin
        msd = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd[k*4 +: 4] != 4'd0) msd = IW'(k);
        end
        ovf = sign_q ? (bcd[BCD_DIGITS*4-1:28] != '0) : (bcd[BCD_DIGITS*4-1:32] != '0);
        disp_next = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (ovf) begin
                disp_next[k] = SEG_DASH;
            end else if (k <= int'(msd)) begin
                disp_next[k] = seg_digit(bcd[k*4 +: 4]);
            end else if (sign_q && (k == int'(msd) + 1)) begin
                disp_next[k] = SEG_DASH;
            end else begin
                disp_next[k] = SEG_BLANK;
            end
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            sign_q <= 1'b0;
            o_done <= 1'b0;
            disp_q <= {{(NUM_DIGITS-1){SEG_BLANK}}, SEG_0};
        end else begin
            if (accept) begin
                sign_q <= i_score[31];
            end
            o_done <= (state == ST_COMMIT);
            if (state == ST_COMMIT) begin
                disp_q <= disp_next;
            end
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            presc <= '0;
            idx   <= '0;
            o_an  <= '1;
            o_sg  <= SEG_BLANK;
        end else begin
            if (presc == PW'(SCAN_DIV - 1)) begin
                presc <= '0;
                idx   <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
            o_an <= ~(NUM_DIGITS'(1) << idx);
            o_sg <= disp_q[idx];
        end
    end

endmodule

// File: tb/tb_m_score_7seg.sv
// tb/tb_m_score_7seg.sv - randomized self-checking bench for m_score_7seg
`timescale 1ns/1ps
module tb_m_score_7seg;

    logic        clk = 1'b0;
    logic        w_rst_n;
    logic [31:0] i_score;
    logic        i_valid;
    logic        o_busy;
    logic        o_done;
    logic [6:0]  o_sg;
    logic [7:0]  o_an;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] SEGT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                         7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    m_score_7seg #(.SCAN_DIV(4), .NUM_DIGITS(8)) dut (
        .clk     (clk),
        .w_rst_n (w_rst_n),
        .i_score (i_score),
        .i_valid (i_valid),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_sg    (o_sg),
        .o_an    (o_an)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: decimal arithmetic on the signed value, digit 0 rightmost.
    function automatic logic [7:0][6:0] model(input logic [31:0] s);
        logic [7:0][6:0] e;
        int     sv;
        longint v, mag, t;
        int     nd;
        bit     neg;
        sv  = s;
        v   = sv;
        neg = (v < 0);
        mag = neg ? -v : v;
        if ((!neg && mag >= 64'd100000000) || (neg && mag >= 64'd10000000)) begin
            for (int k = 0; k < 8; k++) e[k] = 7'h3F;
            return e;
        end
        nd = 1;
        t  = 10;
        while (mag >= t) begin
            nd++;
            t = t * 10;
        end
        t = mag;
        for (int k = 0; k < 8; k++) begin
            e[k] = (k < nd) ? SEGT[int'(t % 10)] : 7'h7F;
            t = t / 10;
        end
        if (neg) e[nd] = 7'h3F;
        return e;
    endfunction

    task automatic check_display(input logic [7:0][6:0] exp, input string tag);
        logic [7:0] seen;
        seen = '0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                if (o_an == ~(8'd1 << k) && !seen[k]) begin
                    seen[k] = 1'b1;
                    check($sformatf("%s_dig%0d", tag, k), {25'd0, o_sg}, {25'd0, exp[k]});
                end
            end
        end
        check({tag, "_all_digits_scanned"}, {24'd0, seen}, 32'hFF);
    endtask

    task automatic convert(input logic [31:0] s, input string tag);
        int done_at;
        int dones;
        done_at = 0;
        dones   = 0;
        @(negedge clk);
        check({tag, "_idle"}, {31'd0, o_busy}, 32'd0);
        i_score = s;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (o_done) begin
                dones++;
                if (done_at == 0) done_at = n;
            end
            if (n == 1 || n == 33) check($sformatf("%s_busy_c%0d", tag, n), {31'd0, o_busy}, 32'd1);
            if (n == 34) check({tag, "_busy_c34"}, {31'd0, o_busy}, 32'd0);
            @(negedge clk);
        end
        check({tag, "_done_cycle"}, done_at, 34);
        check({tag, "_done_count"}, dones, 1);
        check_display(model(s), tag);
    endtask

    initial begin
        logic [31:0] s;
        int          dones;
        int          waited;

        w_rst_n = 1'b0;
        i_valid = 1'b0;
        i_score = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_sg",   {25'd0, o_sg}, 32'h7F);
        check("rst_an",   {24'd0, o_an}, 32'hFF);

        w_rst_n = 1'b1;
        for (int n = 1; n <= 64; n++) begin
            int ix;
            @(negedge clk);
            ix = ((n - 1) / 4) % 8;
            check($sformatf("scan_an_%0d", n), {24'd0, o_an}, {24'd0, ~(8'd1 << ix)});
            check($sformatf("scan_sg_%0d", n), {25'd0, o_sg}, (ix == 0) ? 32'h40 : 32'h7F);
        end

        convert(32'd500000, "p500000");
        convert(-32'sd15000, "n15000");
        convert(32'd100000000, "p_ovf");
        convert(-32'sd10000000, "n_ovf");
        convert(32'h8000_0000, "min_int");
        convert(32'd99999999, "p_max");
        convert(-32'sd9999999, "n_max");
        convert(32'd0, "zero");
        convert(-32'sd1, "neg1");

        for (int r = 0; r < 16; r++) begin
            case ($urandom_range(0, 4))
                0: s = $urandom;
                1: s = $urandom_range(0, 999);
                2: s = -$urandom_range(1, 99999);
                3: s = ($urandom_range(0, 1) != 0) ? -$urandom_range(99999990, 100000009)
                                                    : $urandom_range(99999990, 100000009);
                default: s = -$urandom_range(9999990, 10000009);
            endcase
            convert(s, $sformatf("rand%0d", r));
        end

        // Requests while busy are dropped; a request on the done cycle is accepted.
        dones = 0;
        @(negedge clk);
        i_score = 32'd123;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        for (int n = 1; n <= 34; n++) begin
            if (o_done) dones++;
            if (n == 10) begin
                i_score = -32'sd4567;
                i_valid = 1'b1;
            end
            if (n == 11) i_valid = 1'b0;
            if (n == 34) begin
                i_score = 32'd890123;
                i_valid = 1'b1;
            end
            @(negedge clk);
        end
        i_valid = 1'b0;
        check("drop_one_done", dones, 1);
        check("third_accepted", {31'd0, o_busy}, 32'd1);
        waited = 0;
        while (!o_done && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("third_done_seen", {31'd0, o_done}, 32'd1);
        check_display(model(32'd890123), "third");

        // Reset mid-conversion aborts and restores the reset pattern.
        @(negedge clk);
        i_score = 32'd77777;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        dones = 0;
        for (int n = 1; n < 20; n++) begin
            if (o_done) dones++;
            @(negedge clk);
        end
        w_rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, o_busy}, 32'd0);
        check("abort_an",   {24'd0, o_an}, 32'hFF);
        check("abort_sg",   {25'd0, o_sg}, 32'h7F);
        repeat (3) @(negedge clk);
        check("abort_an_held", {24'd0, o_an}, 32'hFF);
        w_rst_n = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (o_done) dones++;
            if (n == 0) check("abort_first_an", {24'd0, o_an}, 32'hFE);
        end
        check("abort_no_done", dones, 0);
        check_display({{7{7'h7F}}, 7'h40}, "abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
